phoneme_player: RTL
===================

PHONEME_PLAYER -- requirements
Module: phoneme_player

Interface
REQ-001 SHALL have parameter TABLE_BASE, default 23'h0: word address of the phoneme table in sample memory.
REQ-002 SHALL have parameter ADDR_W, default 23: memory word-address width.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: level request from the controller to play one phoneme.
REQ-006 SHALL have port phoneme_sel, input, 8: phoneme index; sampled only when start is accepted.
REQ-007 SHALL have port finish, output, 1: one-cycle pulse when playback of the accepted phoneme ends.
REQ-008 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-009 SHALL have port sample_tick, input, 1: one-cycle sample-rate strobe.
REQ-010 SHALL have port mem_addr, output, ADDR_W: 32-bit word address.
REQ-011 SHALL have port mem_read, output, 1: read request.
REQ-012 SHALL have port mem_waitrequest, input, 1: request stalled while high.
REQ-013 SHALL have port mem_readdatavalid, input, 1: mem_readdata valid this cycle.
REQ-014 SHALL have port mem_readdata, input, 32: read data.
REQ-015 SHALL have port audio_out, output, 16: signed PCM sample.
REQ-016 SHALL have port audio_valid, output, 1: one-cycle pulse when audio_out updates.

Function
REQ-017 SHALL implement states IDLE, RD_START, RD_END, FETCH, WAIT_DATA, PLAY_LO, PLAY_HI, DONE.
REQ-018 IDLE: on start=1, SHALL latch phoneme_sel and go to RD_START next cycle; start in any other state SHALL be ignored.
REQ-019 Table entry for index n: word TABLE_BASE+2n = first sample word, word TABLE_BASE+2n+1 = last sample word (inclusive); only the low ADDR_W bits of each word are used; address arithmetic SHALL wrap modulo 2^ADDR_W.
REQ-020 RD_START/RD_END SHALL each issue one read of the respective table word and wait for its data before advancing.
REQ-021 Read handshake: mem_read and mem_addr SHALL stay constant until a cycle with mem_waitrequest=0; mem_read SHALL deassert the next cycle; at most one read outstanding; data SHALL be captured on the first mem_readdatavalid=1 afterwards.
REQ-022 After RD_END: if first > last, SHALL go directly to DONE with no sample reads and no audio_valid pulses; otherwise cur_addr <= first, go to FETCH.
REQ-023 FETCH SHALL issue a read of cur_addr; WAIT_DATA SHALL hold the captured word and go to PLAY_LO.
REQ-024 PLAY_LO: on sample_tick, audio_out <= word[15:0], audio_valid=1 that cycle, go to PLAY_HI.
REQ-025 PLAY_HI: on sample_tick, audio_out <= word[31:16], audio_valid=1; then if cur_addr==last go to DONE, else cur_addr+1, go to FETCH.
REQ-026 A sample_tick arriving outside PLAY_LO/PLAY_HI SHALL be dropped, not queued.
REQ-027 DONE SHALL assert finish for exactly one cycle and return to IDLE; start high in that DONE cycle SHALL NOT be accepted; start still high in the following IDLE cycle SHALL be accepted as a new request.
REQ-028 audio_out SHALL hold its last value between pulses and after finish.
REQ-029 Latency: start accepted in cycle T -> mem_read=1 with mem_addr=TABLE_BASE+2*phoneme_sel in cycle T+1.

Reset
REQ-030 reset=1 at any clock edge, including mid-read or mid-playback, SHALL force IDLE, finish=0, busy=0, mem_read=0, mem_addr=0, audio_out=0, audio_valid=0; any in-flight mem_readdatavalid SHALL be ignored after reset.
REQ-031 reset SHALL take priority over start in the same cycle.

Verification
REQ-032 Basic: table[6]=100,[7]=101, word100=32'h0002_0001, word101=32'h0004_0003, sel=3, start pulse, tick every 8 cycles -> audio_out 1,2,3,4 with four audio_valid pulses, then one finish pulse, busy low.
REQ-033 Stall: mem_waitrequest high 5 cycles on each read, readdatavalid 3 cycles later -> mem_addr/mem_read stable while stalled, same 4 samples, no extra reads.
REQ-034 Empty: table entry first=200, last=199 -> finish pulse, zero audio_valid pulses, no read at address 199 or 200.
REQ-035 Busy start: start held high and phoneme_sel changed during playback -> second phoneme starts only after finish, using phoneme_sel sampled at that IDLE cycle.
REQ-036 Reset mid-play: reset during PLAY_HI with readdatavalid arriving 1 cycle later -> all outputs at reset values, no audio_valid, next start plays correctly from first word.
REQ-037 Wrap: ADDR_W=23, first=23'h7FFFFF, last=23'h000000 -> first > last, so finish with no samples; first=last=23'h7FFFFF -> exactly 2 samples.

Source files
------------

// File: rtl/phoneme_player.sv
// Phoneme playback engine: looks up a phoneme's sample range in a table held
// in word-addressed sample memory, then streams each 32-bit word as two
// signed 16-bit PCM samples, one per sample_tick.
module phoneme_player #(
  parameter int unsigned       ADDR_W     = 23,
  parameter logic [ADDR_W-1:0] TABLE_BASE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        phoneme_sel,
  output logic              finish,
  output logic              busy,
  input  logic              sample_tick,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  input  logic              mem_waitrequest,
  input  logic              mem_readdatavalid,
  input  logic [31:0]       mem_readdata,
  output logic [15:0]       audio_out,
  output logic              audio_valid
);

  typedef enum logic [2:0] {
    StIdle,
    StRdStart,
    StRdEnd,
    StFetch,
    StWaitData,
    StPlayLo,
    StPlayHi,
    StDone
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] first_q;
  logic [ADDR_W-1:0] last_q;
  logic [ADDR_W-1:0] cur_q;
  logic [31:0]       word_q;

  logic [ADDR_W-1:0] entry_addr;
  logic [ADDR_W-1:0] rd_word;
  logic              rd_data_ok;

  // Table entry for index n lives at TABLE_BASE + 2n; wraps at ADDR_W bits.
  assign entry_addr = TABLE_BASE + (ADDR_W'(phoneme_sel) << 1);
  assign rd_word    = mem_readdata[ADDR_W-1:0];
  // Read data only counts once the request has been accepted (mem_read low),
  // so a stale beat while a new request is still pending is ignored.
  assign rd_data_ok = !mem_read && mem_readdatavalid;

  assign busy   = (state_q != StIdle);
  assign finish = (state_q == StDone);

  // Playback FSM with registered memory and audio outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      mem_read    <= 1'b0;
      mem_addr    <= '0;
      audio_out   <= '0;
      audio_valid <= 1'b0;
      first_q     <= '0;
      last_q      <= '0;
      cur_q       <= '0;
      word_q      <= '0;
    end else begin
      audio_valid <= 1'b0;
      // A request is held until the slave stops stalling, then dropped.
      if (mem_read && !mem_waitrequest) begin
        mem_read <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (start) begin
            mem_addr <= entry_addr;
            mem_read <= 1'b1;
            state_q  <= StRdStart;
          end
        end
        StRdStart: begin
          if (rd_data_ok) begin
            first_q  <= rd_word;
            mem_addr <= mem_addr + 1'b1;
            mem_read <= 1'b1;
            state_q  <= StRdEnd;
          end
        end
        StRdEnd: begin
          if (rd_data_ok) begin
            last_q <= rd_word;
            if (first_q > rd_word) begin
              // Empty range: nothing to fetch or play.
              state_q <= StDone;
            end else begin
              cur_q    <= first_q;
              mem_addr <= first_q;
              mem_read <= 1'b1;
              state_q  <= StFetch;
            end
          end
        end
        StFetch: begin
          if (mem_read && !mem_waitrequest) begin
            state_q <= StWaitData;
          end
        end
        StWaitData: begin
          if (rd_data_ok) begin
            word_q  <= mem_readdata;
            state_q <= StPlayLo;
          end
        end
        StPlayLo: begin
          if (sample_tick) begin
            audio_out   <= word_q[15:0];
            audio_valid <= 1'b1;
            state_q     <= StPlayHi;
          end
        end
        StPlayHi: begin
          if (sample_tick) begin
            audio_out   <= word_q[31:16];
            audio_valid <= 1'b1;
            if (cur_q == last_q) begin
              state_q <= StDone;
            end else begin
              cur_q    <= cur_q + 1'b1;
              mem_addr <= cur_q + 1'b1;
              mem_read <= 1'b1;
              state_q  <= StFetch;
            end
          end
        end
        StDone: begin
          // start is deliberately not looked at here.
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
